// File: rtl/wb_except_commit.sv
// ---------------------------------------------------------------------------
// wb_except_commit
//   Writeback-stage commit and exception unit. Holds the instruction leaving
//   MEM, folds its exception flags and any pending interrupt into a single
//   prioritized event, drives the CSR trap port, raises the pipeline flush
//   and redirect, and gates GPR/CSR writes so a faulting instruction never
//   commits.
//
//   Handshake: an instruction moves MEM->WB on a rising edge where
//   ms_to_ws_valid && ws_allowin are both high. WB is always ready-go in RUN,
//   so ws_allowin is 1 whenever the stage is empty or in RUN.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   ms_to_ws_valid / ws_allowin  MEM->WB handshake
//   ms_pc, ms_vaddr, ms_exc      instruction PC, data address, exc flags
//                                ms_exc = {adef, ine, sys, brk, ale, ertn}
//   ms_rf_*, ms_csr_*            GPR / CSR write requests
//   has_int, ex_entry,
//   ertn_entry                   interrupt pending and targets from CSR file
//   wb_ex, wb_ecode, wb_esubcode,
//   wb_pc, wb_vaddr, eret_flush  trap port to CSR file
//   csr_*, rf_*                  gated write ports
//   flush, flush_pc              pipeline kill and redirect target
//   instret                      committed-instruction counter
//   state_dbg                    FSM state (0 = RUN, 1 = BUBBLE)
// ---------------------------------------------------------------------------
module wb_except_commit #(
    parameter int          PC_W        = 32,
    parameter logic [31:0] INSTRET_RST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ms_to_ws_valid,
    output logic            ws_allowin,
    input  logic [PC_W-1:0] ms_pc,
    input  logic [PC_W-1:0] ms_vaddr,
    input  logic [5:0]      ms_exc,
    input  logic            ms_rf_we,
    input  logic [4:0]      ms_rf_waddr,
    input  logic [31:0]     ms_rf_wdata,
    input  logic            ms_csr_we,
    input  logic [13:0]     ms_csr_num,
    input  logic [31:0]     ms_csr_wmask,
    input  logic [31:0]     ms_csr_wvalue,
    input  logic            has_int,
    input  logic [PC_W-1:0] ex_entry,
    input  logic [PC_W-1:0] ertn_entry,
    output logic            wb_ex,
    output logic            eret_flush,
    output logic [5:0]      wb_ecode,
    output logic [8:0]      wb_esubcode,
    output logic [PC_W-1:0] wb_pc,
    output logic [PC_W-1:0] wb_vaddr,
    output logic            csr_we,
    output logic [13:0]     csr_wnum,
    output logic [31:0]     csr_wmask,
    output logic [31:0]     csr_wvalue,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [31:0]     rf_wdata,
    output logic            flush,
    output logic [PC_W-1:0] flush_pc,
    output logic [31:0]     instret,
    output logic            state_dbg
);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_BUBBLE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic            ws_valid;
    logic [PC_W-1:0] ws_pc;
    logic [PC_W-1:0] ws_vaddr;
    logic [5:0]      ws_exc;
    logic            ws_rf_we;
    logic [4:0]      ws_rf_waddr;
    logic [31:0]     ws_rf_wdata;
    logic            ws_csr_we;
    logic [13:0]     ws_csr_num;
    logic [31:0]     ws_csr_wmask;
    logic [31:0]     ws_csr_wvalue;
    logic [31:0]     instret_q;
    logic            commit;
    logic            accept;

    // Nothing is taken while flushing or in the bubble: whatever MEM offers
    // then is younger than the trapping instruction and is being killed.
    assign accept = ms_to_ws_valid && (state == S_RUN) && !flush;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:    if (flush) state_nxt = S_BUBBLE;
            S_BUBBLE: state_nxt = S_RUN;
            default:  state_nxt = S_RUN;
        endcase
    end

    // ---------------- output / event logic ----------------
    always_comb begin
        wb_ex      = 1'b0;
        eret_flush = 1'b0;
        wb_ecode   = 6'h00;
        wb_vaddr   = '0;
        if (ws_valid && (state == S_RUN)) begin
            if (has_int) begin
                wb_ex    = 1'b1;
                wb_ecode = 6'h00;
            end else if (ws_exc[5]) begin
                wb_ex    = 1'b1;
                wb_ecode = 6'h08;
                wb_vaddr = ws_pc;
            end else if (ws_exc[4]) begin
                wb_ex    = 1'b1;
                wb_ecode = 6'h0D;
            end else if (ws_exc[3]) begin
                wb_ex    = 1'b1;
                wb_ecode = 6'h0B;
            end else if (ws_exc[2]) begin
                wb_ex    = 1'b1;
                wb_ecode = 6'h0C;
            end else if (ws_exc[1]) begin
                wb_ex    = 1'b1;
                wb_ecode = 6'h09;
                wb_vaddr = ws_vaddr;
            end else if (ws_exc[0]) begin
                eret_flush = 1'b1;
            end
        end
        commit   = ws_valid && (state == S_RUN) && !wb_ex;
        // ertn counts as committed but writes nothing.
        rf_we    = commit && ws_rf_we && !ws_exc[0];
        csr_we   = commit && ws_csr_we && !ws_exc[0];
        flush    = wb_ex || eret_flush;
        flush_pc = '0;
        if (wb_ex)           flush_pc = ex_entry;
        else if (eret_flush) flush_pc = ertn_entry;
    end

    assign ws_allowin  = !ws_valid || (state == S_RUN);
    assign wb_esubcode = 9'h000;
    assign wb_pc       = ws_pc;
    assign csr_wnum    = ws_csr_num;
    assign csr_wmask   = ws_csr_wmask;
    assign csr_wvalue  = ws_csr_wvalue;
    assign rf_waddr    = ws_rf_waddr;
    assign rf_wdata    = ws_rf_wdata;
    assign instret     = instret_q;
    assign state_dbg   = state;

    // ---------------- WB register and commit counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_valid      <= 1'b0;
            ws_pc         <= '0;
            ws_vaddr      <= '0;
            ws_exc        <= '0;
            ws_rf_we      <= 1'b0;
            ws_rf_waddr   <= '0;
            ws_rf_wdata   <= '0;
            ws_csr_we     <= 1'b0;
            ws_csr_num    <= '0;
            ws_csr_wmask  <= '0;
            ws_csr_wvalue <= '0;
            instret_q     <= INSTRET_RST;
        end else begin
            ws_valid <= accept;
            if (accept) begin
                ws_pc         <= ms_pc;
                ws_vaddr      <= ms_vaddr;
                ws_exc        <= ms_exc;
                ws_rf_we      <= ms_rf_we;
                ws_rf_waddr   <= ms_rf_waddr;
                ws_rf_wdata   <= ms_rf_wdata;
                ws_csr_we     <= ms_csr_we;
                ws_csr_num    <= ms_csr_num;
                ws_csr_wmask  <= ms_csr_wmask;
                ws_csr_wvalue <= ms_csr_wvalue;
            end
            if (commit) instret_q <= instret_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_except_commit.sv
module tb_wb_except_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc, ms_vaddr;
    logic [5:0]  ms_exc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask, ms_csr_wvalue;
    logic        has_int;
    logic [31:0] ex_entry, ertn_entry;

    logic        ws_allowin, wb_ex, eret_flush, csr_we, rf_we, flush, state_dbg;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr, csr_wmask, csr_wvalue, rf_wdata, flush_pc, instret;
    logic [13:0] csr_wnum;
    logic [4:0]  rf_waddr;

    logic        w_ws_allowin, w_wb_ex, w_eret_flush, w_csr_we, w_rf_we, w_flush, w_state_dbg;
    logic [5:0]  w_wb_ecode;
    logic [8:0]  w_wb_esubcode;
    logic [31:0] w_wb_pc, w_wb_vaddr, w_csr_wmask, w_csr_wvalue, w_rf_wdata, w_flush_pc, w_instret;
    logic [13:0] w_csr_wnum;
    logic [4:0]  w_rf_waddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_except_commit #(.PC_W(32)) dut (
        .clk(clk), .rst(rst), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_exc(ms_exc),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask),
        .ms_csr_wvalue(ms_csr_wvalue), .has_int(has_int), .ex_entry(ex_entry),
        .ertn_entry(ertn_entry), .wb_ex(wb_ex), .eret_flush(eret_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .flush_pc(flush_pc), .instret(instret), .state_dbg(state_dbg)
    );

    // Second copy whose counter resets just below the wrap point.
    wb_except_commit #(.PC_W(32), .INSTRET_RST(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(w_ws_allowin),
        .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_exc(ms_exc),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask),
        .ms_csr_wvalue(ms_csr_wvalue), .has_int(has_int), .ex_entry(ex_entry),
        .ertn_entry(ertn_entry), .wb_ex(w_wb_ex), .eret_flush(w_eret_flush),
        .wb_ecode(w_wb_ecode), .wb_esubcode(w_wb_esubcode), .wb_pc(w_wb_pc), .wb_vaddr(w_wb_vaddr),
        .csr_we(w_csr_we), .csr_wnum(w_csr_wnum), .csr_wmask(w_csr_wmask), .csr_wvalue(w_csr_wvalue),
        .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
        .flush(w_flush), .flush_pc(w_flush_pc), .instret(w_instret), .state_dbg(w_state_dbg)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] pc, input logic [31:0] va, input logic [5:0] exc,
                         input logic rfwe, input logic csrwe);
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_pc          = pc;
        ms_vaddr       = va;
        ms_exc         = exc;
        ms_rf_we       = rfwe;
        ms_rf_waddr    = pc[6:2];
        ms_rf_wdata    = pc ^ 32'h5A5A_0000;
        ms_csr_we      = csrwe;
        ms_csr_num     = 14'h0005;
        ms_csr_wmask   = 32'hFFFF_FFFF;
        ms_csr_wvalue  = 32'h0000_00AB;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        ms_exc         = 6'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ms_to_ws_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        ms_to_ws_valid = 1'b0; ms_pc = '0; ms_vaddr = '0; ms_exc = '0;
        ms_rf_we = 1'b0; ms_rf_waddr = '0; ms_rf_wdata = '0;
        ms_csr_we = 1'b0; ms_csr_num = '0; ms_csr_wmask = '0; ms_csr_wvalue = '0;
        has_int = 1'b0; ex_entry = 32'h1c00_8000; ertn_entry = 32'h1c00_0100;
        #1;
        checks++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", ws_allowin); end
        checks++; if ({wb_ex, eret_flush, flush, rf_we, csr_we} !== 5'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=00000", {wb_ex, eret_flush, flush, rf_we, csr_we}); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret got=%h exp=0", instret); end
        checks++; if (wb_pc !== 32'h0 || wb_vaddr !== 32'h0) begin errors++; $display("FAIL reset_data got pc=%h va=%h exp=0", wb_pc, wb_vaddr); end
        checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state got=%b exp=0", state_dbg); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(32'h1c00_0000, 32'h0, 6'b0, 1'b1, 1'b1);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd0) begin errors++; $display("FAIL b2b_rf0 got we=%b a=%h exp we=1 a=0", rf_we, rf_waddr); end
        checks++; if (csr_we !== 1'b1 || csr_wnum !== 14'h5 || csr_wvalue !== 32'hAB) begin errors++; $display("FAIL b2b_csr got we=%b n=%h v=%h exp 1/5/ab", csr_we, csr_wnum, csr_wvalue); end
        checks++; if (flush !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL b2b_0 got flush=%b instret=%0d exp 0/0", flush, instret); end
        drive(32'h1c00_0004, 32'h0, 6'b0, 1'b1, 1'b0);
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h465A_0004 || flush !== 1'b0) begin errors++; $display("FAIL b2b_1 got we=%b d=%h flush=%b exp 1/465a0004/0", rf_we, rf_wdata, flush); end
        checks++; if (instret !== 32'd1 || csr_we !== 1'b0) begin errors++; $display("FAIL b2b_1cnt got instret=%0d csr_we=%b exp 1/0", instret, csr_we); end
        drive(32'h1c00_0008, 32'h0, 6'b0, 1'b1, 1'b0);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || flush !== 1'b0) begin errors++; $display("FAIL b2b_2 got we=%b a=%h flush=%b exp 1/2/0", rf_we, rf_waddr, flush); end
        idle_cycle();
        checks++; if (instret !== 32'd3 || rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end got instret=%0d rf_we=%b exp 3/0", instret, rf_we); end
    endtask

    task automatic test_sys();
        drive(32'h1c00_0010, 32'h0, 6'b001000, 1'b1, 1'b1);
        checks++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h0B || wb_esubcode !== 9'h0) begin errors++; $display("FAIL sys_ex got ex=%b ec=%h es=%h exp 1/0b/0", wb_ex, wb_ecode, wb_esubcode); end
        checks++; if (wb_pc !== 32'h1c00_0010 || flush_pc !== 32'h1c00_8000 || flush !== 1'b1) begin errors++; $display("FAIL sys_pc got pc=%h fpc=%h fl=%b exp 1c000010/1c008000/1", wb_pc, flush_pc, flush); end
        checks++; if (rf_we !== 1'b0 || csr_we !== 1'b0 || eret_flush !== 1'b0) begin errors++; $display("FAIL sys_gate got rf=%b csr=%b eret=%b exp 0/0/0", rf_we, csr_we, eret_flush); end
        // Younger instruction offered during the trap cycle: dropped.
        drive(32'h1c00_0014, 32'h0, 6'b0, 1'b1, 1'b0);
        checks++; if (state_dbg !== 1'b1 || wb_ex !== 1'b0 || flush !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL sys_bubble got st=%b ex=%b fl=%b rf=%b exp 1/0/0/0", state_dbg, wb_ex, flush, rf_we); end
        checks++; if (instret !== 32'd3 || ws_allowin !== 1'b1) begin errors++; $display("FAIL sys_bubble_cnt got instret=%0d allowin=%b exp 3/1", instret, ws_allowin); end
        // Offered during the bubble: dropped as well.
        drive(32'h1c00_0018, 32'h0, 6'b0, 1'b1, 1'b0);
        checks++; if (state_dbg !== 1'b0 || rf_we !== 1'b0 || instret !== 32'd3) begin errors++; $display("FAIL sys_drop got st=%b rf=%b instret=%0d exp 0/0/3", state_dbg, rf_we, instret); end
        drive(32'h1c00_8000, 32'h0, 6'b0, 1'b1, 1'b0);
        checks++; if (rf_we !== 1'b1 || wb_pc !== 32'h1c00_8000) begin errors++; $display("FAIL sys_resume got rf=%b pc=%h exp 1/1c008000", rf_we, wb_pc); end
        idle_cycle();
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL sys_cnt got=%0d exp=4", instret); end
    endtask

    task automatic test_brk_ale();
        drive(32'h1c00_0020, 32'h0000_0003, 6'b000110, 1'b1, 1'b0);
        checks++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h0C) begin errors++; $display("FAIL brk_ale got ex=%b ec=%h exp 1/0c", wb_ex, wb_ecode); end
        idle_cycle();
        idle_cycle();
        drive(32'h1c00_0024, 32'h0000_0003, 6'b000010, 1'b1, 1'b0);
        checks++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h09 || wb_vaddr !== 32'h3) begin errors++; $display("FAIL ale got ex=%b ec=%h va=%h exp 1/09/3", wb_ex, wb_ecode, wb_vaddr); end
        idle_cycle();
        idle_cycle();
        drive(32'h1c00_0028, 32'h0000_0003, 6'b100000, 1'b1, 1'b0);
        checks++; if (wb_ecode !== 6'h08 || wb_vaddr !== 32'h1c00_0028) begin errors++; $display("FAIL adef got ec=%h va=%h exp 08/1c000028", wb_ecode, wb_vaddr); end
        idle_cycle();
        idle_cycle();
        drive(32'h1c00_002c, 32'h0, 6'b011000, 1'b1, 1'b0);
        checks++; if (wb_ecode !== 6'h0D) begin errors++; $display("FAIL ine_over_sys got ec=%h exp 0d", wb_ecode); end
        idle_cycle();
        idle_cycle();
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL fault_cnt got=%0d exp=4", instret); end
    endtask

    task automatic test_int_ertn();
        @(negedge clk);
        has_int = 1'b1;
        drive(32'h1c00_0200, 32'h0, 6'b000001, 1'b0, 1'b0);
        checks++; if (wb_ex !== 1'b1 || wb_ecode !== 6'h00 || eret_flush !== 1'b0) begin errors++; $display("FAIL int_ertn got ex=%b ec=%h eret=%b exp 1/00/0", wb_ex, wb_ecode, eret_flush); end
        checks++; if (wb_pc !== 32'h1c00_0200 || flush_pc !== 32'h1c00_8000) begin errors++; $display("FAIL int_pc got pc=%h fpc=%h exp 1c000200/1c008000", wb_pc, flush_pc); end
        // has_int stays high through the bubble.
        idle_cycle();
        checks++; if (state_dbg !== 1'b1 || wb_ex !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL int_bubble got st=%b ex=%b fl=%b exp 1/0/0", state_dbg, wb_ex, flush); end
        @(negedge clk);
        has_int = 1'b0;
        drive(32'h1c00_0300, 32'h0, 6'b000001, 1'b1, 1'b1);
        checks++; if (eret_flush !== 1'b1 || wb_ex !== 1'b0 || flush !== 1'b1 || flush_pc !== 32'h1c00_0100) begin errors++; $display("FAIL ertn got eret=%b ex=%b fl=%b fpc=%h exp 1/0/1/1c000100", eret_flush, wb_ex, flush, flush_pc); end
        checks++; if (rf_we !== 1'b0 || csr_we !== 1'b0) begin errors++; $display("FAIL ertn_nowrite got rf=%b csr=%b exp 0/0", rf_we, csr_we); end
        idle_cycle();
        checks++; if (instret !== 32'd5 || state_dbg !== 1'b1) begin errors++; $display("FAIL ertn_cnt got instret=%0d st=%b exp 5/1", instret, state_dbg); end
        idle_cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (w_instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffffffff", w_instret); end
        drive(32'h1c00_0400, 32'h0, 6'b0, 1'b1, 1'b0);
        idle_cycle();
        checks++; if (w_instret !== 32'h0 || instret !== 32'd1) begin errors++; $display("FAIL wrap got w=%h main=%h exp 0/1", w_instret, instret); end
    endtask

    task automatic test_reset_in_bubble();
        drive(32'h1c00_0500, 32'h0, 6'b001000, 1'b1, 1'b0);
        drive(32'h1c00_0504, 32'h0, 6'b0, 1'b1, 1'b0);
        checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL rstb_pre got st=%b exp 1", state_dbg); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (state_dbg !== 1'b0 || ws_allowin !== 1'b1 || instret !== 32'h0) begin errors++; $display("FAIL rstb_state got st=%b allowin=%b instret=%h exp 0/1/0", state_dbg, ws_allowin, instret); end
        checks++; if ({wb_ex, eret_flush, flush, rf_we, csr_we} !== 5'b0 || wb_pc !== 32'h0 || flush_pc !== 32'h0) begin errors++; $display("FAIL rstb_out got p=%b pc=%h fpc=%h exp 0/0/0", {wb_ex, eret_flush, flush, rf_we, csr_we}, wb_pc, flush_pc); end
        @(negedge clk);
        rst = 1'b0;
        ms_to_ws_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rf_we !== 1'b0 || instret !== 32'h0) begin errors++; $display("FAIL rstb_after got rf=%b instret=%h exp 0/0", rf_we, instret); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sys();
        test_brk_ale();
        test_int_ertn();
        test_wrap();
        test_reset_in_bubble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
